// File: rtl/divider_pkg.sv
// Shared widths and FSM state set for the 8-by-4 divider and its multiply-back checker.
// Keeping both blocks on these constants keeps their operand widths matched.
package divider_pkg;

  localparam int W_Q = 8;
  localparam int W_B = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result width: Q*B+R with R < 2^W_Q fits in W_Q+W_B bits.
  function automatic int w_p(input int wq, input int wb);
    return wq + wb;
  endfunction

endpackage

// File: rtl/divider_8bit_check_mul.sv
// Sequential shift-add multiply-accumulate rebuilding dividend = quotient*divisor + remainder.
// One operation in flight; W_B iteration cycles per operation with no early exit.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// in_ready is high only in IDLE; once out_valid rises, dividend/ovf/rem_invalid stay
// stable until the edge where out_ready is seen high.
module divider_8bit_check_mul
  import divider_pkg::*;
#(
  parameter int W_Q_P = W_Q,
  parameter int W_B_P = W_B
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W_Q_P-1:0]             quotient,
  input  logic [W_B_P-1:0]             divisor,
  input  logic [W_Q_P-1:0]             remainder,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [w_p(W_Q_P,W_B_P)-1:0]  dividend,
  output logic                         ovf,
  output logic                         rem_invalid
);

  localparam int WP = w_p(W_Q_P, W_B_P);
  localparam int CW = $clog2(W_B_P) + 1;

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_CALC = 2'(CALC);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WP-1:0]    acc;
  logic [WP-1:0]    acc_next;
  logic [WP-1:0]    q_sh;
  logic [W_B_P-1:0] b_sh;
  logic             rem_inv_r;

  assign in_ready = (state == ST_IDLE);

  always_comb begin
    acc_next = acc;
    if (b_sh[0]) acc_next = acc + q_sh;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid   <= 1'b0;
      dividend    <= '0;
      ovf         <= 1'b0;
      rem_invalid <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      q_sh        <= '0;
      b_sh        <= '0;
      rem_inv_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc       <= WP'(remainder);
            q_sh      <= WP'(quotient);
            b_sh      <= divisor;
            rem_inv_r <= (remainder >= W_Q_P'(divisor));
            cnt       <= '0;
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc  <= acc_next;
          q_sh <= q_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          // Last iteration: publish the final sum straight from acc_next.
          if (cnt == CW'(W_B_P - 1)) begin
            dividend    <= acc_next;
            ovf         <= |acc_next[WP-1:W_Q_P];
            rem_invalid <= rem_inv_r;
            out_valid   <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_8bit_check_mul.sv
// Directed and randomized checks of the multiply-back block against Q*B+R arithmetic,
// including a full round trip over every legal 8-by-4 division.
module tb_divider_8bit_check_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  quotient;
  logic [3:0]  divisor;
  logic [7:0]  remainder;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] dividend;
  logic        ovf;
  logic        rem_invalid;

  int checks   = 0;
  int failures = 0;

  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  divider_8bit_check_mul dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .divisor(divisor), .remainder(remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .dividend(dividend), .ovf(ovf), .rem_invalid(rem_invalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {rem_invalid, ovf, dividend} from plain arithmetic.
  function automatic logic [13:0] model(input int q, input int b, input int r);
    int d;
    d = q * b + r;
    return {(r >= b) ? 1'b1 : 1'b0, (d > 255) ? 1'b1 : 1'b0, 12'(d)};
  endfunction

  // One full transaction: accept, wait for result, optionally stall, then handshake.
  task automatic run_op(input logic [7:0] q, input logic [3:0] b, input logic [7:0] r,
                        input int hold, output logic [13:0] res, output int lat);
    logic [11:0] held;
    in_valid = 1'b1; quotient = q; divisor = b; remainder = r;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    quotient = 8'($urandom); divisor = 4'($urandom); remainder = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res  = {rem_invalid, ovf, dividend};
    held = dividend;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      quotient = 8'($urandom); divisor = 4'($urandom); remainder = 8'($urandom);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_dividend", 32'(dividend), 32'(held));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [13:0] res;
    logic [13:0] e;
    int lat, cyc, last_hs, n_out, q, b, r, a;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    quotient = '0; divisor = '0; remainder = '0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dividend", 32'(dividend), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_rem_invalid", 32'(rem_invalid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Directed cases
    run_op(8'd28, 4'd7, 8'd4, 0, res, lat);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_result", 32'(res), 32'({1'b0, 1'b0, 12'd200}));
    chk("t1_in_ready_after", 32'(in_ready), 32'd1);
    chk("t1_out_valid_after", 32'(out_valid), 32'd0);
    chk("t1_dividend_kept", 32'(dividend), 32'd200);

    run_op(8'd255, 4'd15, 8'd255, 0, res, lat);
    chk("t2_latency", 32'(lat), 32'd4);
    chk("t2_result", 32'(res), 32'({1'b1, 1'b1, 12'hFF0}));

    run_op(8'h55, 4'd0, 8'h12, 0, res, lat);
    chk("t3_latency", 32'(lat), 32'd4);
    chk("t3_result", 32'(res), 32'({1'b1, 1'b0, 12'h012}));

    run_op(8'd9, 4'd3, 8'd2, 3, res, lat);
    chk("t4_latency", 32'(lat), 32'd4);
    chk("t4_result", 32'(res), 32'({1'b0, 1'b0, 12'd29}));
    chk("t4_in_ready_after", 32'(in_ready), 32'd1);
    chk("t4_dividend_kept", 32'(dividend), 32'd29);
    tick();
    chk("t4_no_spurious_accept", 32'(out_valid), 32'd0);

    // Reset two cycles after accept discards the operation.
    in_valid = 1'b1; quotient = 8'd100; divisor = 4'd9; remainder = 8'd3;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_dividend", 32'(dividend), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_result", 32'(out_valid), 32'd0);
    end

    // Random sweep with both handshakes held high.
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; last_hs = -1; n_out = 0;
    while (n_out < 20 && cyc < 400) begin
      q = $urandom_range(0, 255); b = $urandom_range(0, 15); r = $urandom_range(0, 255);
      quotient = 8'(q); divisor = 4'(b); remainder = 8'(r);
      if (in_ready) exp_q.push_back(model(q, b, r));
      if (out_valid) begin
        if (exp_q.size() == 0) chk("t6_unexpected_result", 32'(dividend), 32'hDEAD);
        else begin
          e = exp_q.pop_front();
          chk("t6_result", 32'({rem_invalid, ovf, dividend}), 32'(e));
        end
        if (last_hs >= 0) chk("t6_spacing", 32'(cyc - last_hs), 32'd6);
        last_hs = cyc;
        n_out++;
      end
      tick();
      cyc++;
    end
    chk("t6_count", 32'(n_out), 32'd20);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        chk("t6_drain", 32'({rem_invalid, ovf, dividend}), 32'(e));
      end
      tick();
    end
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
    tick();

    // Round trip over every legal divider output.
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        a = ai;
        q = a / bi;
        r = a % bi;
        run_op(8'(q), 4'(bi), 8'(r), 0, res, lat);
        if (res[11:0] !== 12'(a) || res[13] !== 1'b0 || lat != 4)
          chk("rt_result", 32'({lat[3:0], res}), 32'({4'd4, 1'b0, res[12], 12'(a)}));
        else
          checks++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
